serial_adder: RTL and testbench

//   Parametrised bit-serial adder/subtractor: the sequential successor to the half adder.

---
 rtl/serial_adder.sv | 61 ++++++
 tb/tb_serial_adder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor built from one full-adder cell and a carry flip-flop
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0] cnt;
  logic c, s, c_nx;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // full-adder cell on the current LSBs plus next-state selection
  always_comb begin
    s        = a_sh[0] ^ b_sh[0] ^ c;
    c_nx     = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
               state == RUN  ? (cnt == LAST ? DONE : RUN) :
                               (out_ready ? IDLE : DONE);
  end
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // operand shifters, carry, result and bit counter; sum fills from the MSB side
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      sum  <= '0;
      cout <= 1'b0;
      c    <= 1'b0;
      cnt  <= '0;
    end else if (state == IDLE && in_valid) begin
      a_sh <= a;
      b_sh <= sub ? ~b : b;
      c    <= sub | cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      sum  <= (sum >> 1) | (WIDTH'(s) << (WIDTH - 1));
      c    <= c_nx;
      cnt  <= cnt + CW'(1);
      if (cnt == LAST) cout <= c_nx;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: checks WIDTH=8, 1 and 16 instances against an arithmetic reference model
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst, cin, sub, ordy;
  logic [2:0] iv;
  logic [15:0] a, b;
  logic ir8, ov8, co8, ir1, ov1, co1, ir16, ov16, co16;
  logic [7:0] s8;
  logic [0:0] s1;
  logic [15:0] s16;
  int n_cmp = 0, n_bad = 0;
  int wd [3] = '{8, 1, 16};
  logic [16:0] exp_r [3];
  logic [16:0] g;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub), .sum(s8), .cout(co8), .out_valid(ov8), .out_ready(ordy));
  serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
    .a(a[0:0]), .b(b[0:0]), .cin(cin), .sub(sub), .sum(s1), .cout(co1), .out_valid(ov1), .out_ready(ordy));
  serial_adder #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir16),
    .a(a), .b(b), .cin(cin), .sub(sub), .sum(s16), .cout(co16), .out_valid(ov16), .out_ready(ordy));

  function automatic logic [16:0] res(int k);
    return k == 0 ? {8'b0, co8, s8} : k == 1 ? {15'b0, co1, s1} : {co16, s16};
  endfunction
  function automatic logic ov(int k);
    return k == 0 ? ov8 : k == 1 ? ov1 : ov16;
  endfunction
  function automatic logic ir(int k);
    return k == 0 ? ir8 : k == 1 ? ir1 : ir16;
  endfunction

  function automatic logic [16:0] model(int w, logic [15:0] x, logic [15:0] y, logic ci, logic sb);
    longint m, yy, r;
    m  = (64'd1 << w) - 1;
    yy = sb ? (~longint'(y) & m) : (longint'(y) & m);
    r  = (longint'(x) & m) + yy + (sb ? 64'd1 : longint'(ci));
    return 17'(r & ((m << 1) | 64'd1));
  endfunction

  task automatic check(string nm, logic [16:0] got, logic [16:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (ov(k) === 1'b1 && rst === 1'b0)
        check($sformatf("result_w%0d", wd[k]), res(k), exp_r[k]);

  task automatic run(int k, logic [15:0] x, logic [15:0] y, logic ci, logic sb, output logic [16:0] got);
    int n;
    a = x; b = y; cin = ci; sub = sb;
    exp_r[k] = model(wd[k], x, y, ci, sb);
    iv[k] = 1'b1;
    @(posedge clk);
    #1 iv[k] = 1'b0;
    n = 1;
    while (!ov(k) && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check($sformatf("latency_w%0d", wd[k]), 17'(n), 17'(wd[k] + 1));
    got = res(k);
    ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
    check("ov_drop", 17'(ov(k)), 17'd0);
    check("ir_back", 17'(ir(k)), 17'd1);
  endtask

  initial begin
    int n;
    logic [15:0] rx, ry;
    rst = 1'b1; iv = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; ordy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_ir", 17'(ir(k)), 17'd1);
      check("rst_ov", 17'(ov(k)), 17'd0);
      check("rst_res", res(k), 17'd0);
    end
    run(0, 16'h0F, 16'h01, 1'b0, 1'b0, g); check("add_0f_01", g, 17'h010);
    run(0, 16'hFF, 16'h01, 1'b0, 1'b0, g); check("add_ff_01", g, 17'h100);
    run(0, 16'hFF, 16'hFF, 1'b1, 1'b0, g); check("add_ff_ff_c", g, 17'h1FF);
    run(0, 16'h05, 16'h07, 1'b1, 1'b1, g); check("sub_05_07", g, 17'h0FE);
    run(0, 16'h07, 16'h05, 1'b0, 1'b1, g); check("sub_07_05", g, 17'h102);
    a = 16'h12; b = 16'h34; cin = 1'b0; sub = 1'b0;
    exp_r[0] = model(8, 16'h12, 16'h34, 1'b0, 1'b0);
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    n = 0;
    while (!ov8 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1'b1; a = 16'(i * 37 + 5); b = 16'(i * 11);
      @(posedge clk);
      #1 check("bp_res", res(0), 17'h046);
      check("bp_ov", 17'(ov8), 17'd1);
      check("bp_ir", 17'(ir8), 17'd0);
    end
    iv[0] = 1'b0; ordy = 1'b1;
    @(posedge clk);
    #1 ordy = 1'b0;
    check("bp_release_ov", 17'(ov8), 17'd0);
    check("bp_release_ir", 17'(ir8), 17'd1);
    check("bp_hold_res", res(0), 17'h046);
    a = 16'hAA; b = 16'h55;
    exp_r[0] = model(8, 16'hAA, 16'h55, 1'b0, 1'b0);
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_ir", 17'(ir8), 17'd1);
    check("mid_rst_ov", 17'(ov8), 17'd0);
    check("mid_rst_res", res(0), 17'd0);
    repeat (10) @(posedge clk);
    #1 check("mid_rst_quiet", 17'(ov8), 17'd0);
    run(0, 16'h03, 16'h04, 1'b0, 1'b0, g); check("after_rst_3_4", g, 17'h007);
    for (int i = 0; i < 8; i++) begin
      rx = 16'((i >> 2) & 1); ry = 16'((i >> 1) & 1);
      run(1, rx, ry, i[0], 1'b0, g);
      check($sformatf("fa_%0d", i), g, 17'(rx + ry + 16'(i[0])));
    end
    for (int i = 0; i < 200; i++) begin
      rx = 16'($urandom); ry = 16'($urandom);
      run(2, rx, ry, 1'($urandom), 1'($urandom), g);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
